// File: rtl/matrix_scan_driver.sv
// Serial LED matrix row scanner: a double-buffered 8x8 frame is shifted out
// row by row as 8 column bits followed by an active-low row-select byte.
module matrix_scan_driver #(
    parameter int SCLK_DIV    = 4,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0][7:0] dataMatrix,
    input  logic            load,
    input  logic            enable,
    output logic            ser_data,
    output logic            ser_clk,
    output logic            ser_latch,
    output logic [2:0]      row_idx,
    output logic            frame_done,
    output logic            busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, HOLD} state_t;

    localparam logic [31:0] BIT_LAST  = 32'(2 * SCLK_DIV - 1);
    localparam logic [31:0] SCLK_HIGH = 32'(SCLK_DIV);
    localparam logic [31:0] LAT_LAST  = 32'(SCLK_DIV - 1);
    localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);

    state_t          state;
    logic [7:0][7:0] shadow;
    logic [7:0][7:0] active;
    logic [31:0]     cnt;
    logic [3:0]      bit_cnt;
    logic [15:0]     sreg;

    logic            start;
    logic [2:0]      row_next;
    logic [7:0][7:0] frame_next;
    logic [15:0]     word_next;

    // A new frame is taken only at the row-0 boundary; a load on that
    // very edge bypasses the shadow so the freshest frame is shown.
    always_comb begin
        start = enable && ((state == IDLE) ||
                ((state == HOLD) && (cnt == HOLD_LAST)));
        row_next = (state == HOLD) ? row_idx + 3'd1 : 3'd0;
        frame_next = active;
        if (row_next == 3'd0)
            frame_next = load ? dataMatrix : shadow;
        word_next = {frame_next[row_next], ~(8'b1 << row_next)};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            row_idx    <= 3'd0;
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            active     <= '0;
            shadow     <= '0;
            cnt        <= '0;
            bit_cnt    <= '0;
            sreg       <= '0;
        end else begin
            if (load)
                shadow <= dataMatrix;
            frame_done <= 1'b0;
            if (start) begin
                state     <= SHIFT;
                row_idx   <= row_next;
                busy      <= 1'b1;
                if (row_next == 3'd0)
                    active <= frame_next;
                ser_data  <= word_next[15];
                sreg      <= word_next << 1;
                ser_clk   <= 1'b0;
                ser_latch <= 1'b0;
                cnt       <= '0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    SHIFT: begin
                        if (cnt == BIT_LAST) begin
                            cnt     <= '0;
                            ser_clk <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                state     <= LATCH;
                                ser_latch <= 1'b1;
                                ser_data  <= 1'b0;
                            end else begin
                                bit_cnt  <= bit_cnt + 4'd1;
                                ser_data <= sreg[15];
                                sreg     <= sreg << 1;
                            end
                        end else begin
                            cnt     <= cnt + 32'd1;
                            ser_clk <= (cnt + 32'd1) >= SCLK_HIGH;
                        end
                    end
                    LATCH: begin
                        if (cnt == LAT_LAST) begin
                            state      <= HOLD;
                            ser_latch  <= 1'b0;
                            cnt        <= '0;
                            frame_done <= (row_idx == 3'd7) &&
                                          (HOLD_LAST == 32'd0);
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            state   <= IDLE;
                            row_idx <= 3'd0;
                            busy    <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            cnt        <= cnt + 32'd1;
                            frame_done <= (row_idx == 3'd7) &&
                                          ((cnt + 32'd1) == HOLD_LAST);
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        ser_data <= 1'b0;
                        ser_clk  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver: frame scan, double buffering,
// enable drop, mid-row reset, and the minimum-parameter timing.
module tb_matrix_scan_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            load;
    logic            enable;
    logic            load2;
    logic            enable2;
    logic [7:0][7:0] dataMatrix;

    logic       ser_data, ser_clk, ser_latch, frame_done, busy;
    logic [2:0] row_idx;
    logic       ser_data2, ser_clk2, ser_latch2, frame_done2, busy2;
    logic [2:0] row_idx2;

    matrix_scan_driver #(.SCLK_DIV(2), .HOLD_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .dataMatrix(dataMatrix),
        .load(load), .enable(enable),
        .ser_data(ser_data), .ser_clk(ser_clk),
        .ser_latch(ser_latch), .row_idx(row_idx),
        .frame_done(frame_done), .busy(busy)
    );

    matrix_scan_driver #(.SCLK_DIV(1), .HOLD_CYCLES(1)) dut_min (
        .clk(clk), .reset(reset), .dataMatrix(dataMatrix),
        .load(load2), .enable(enable2),
        .ser_data(ser_data2), .ser_clk(ser_clk2),
        .ser_latch(ser_latch2), .row_idx(row_idx2),
        .frame_done(frame_done2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  f0 [8];
    logic [7:0]  fb [8];
    logic [15:0] bits [3][8];
    int          nbits [3][8];
    int          nlat [3][8];
    int          lat_at [3][8];
    int          fd_n, fd_first, fr, rw, act, tog;
    logic        prev_sclk;
    logic [15:0] word;
    logic [7:0]  sel;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] row_word(input logic [7:0] d,
                                             input int r);
        logic [7:0] one;
        one = 8'h01;
        return {d, ~(one << r)};
    endfunction

    initial begin
        f0 = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h55, 8'hC3};
        for (int i = 0; i < 8; i++) fb[i] = 8'(8'h90 + i);
        for (int f = 0; f < 3; f++)
            for (int r = 0; r < 8; r++) begin
                bits[f][r] = '0;
                nbits[f][r] = 0;
                nlat[f][r] = 0;
                lat_at[f][r] = 0;
            end
        fd_n = 0;
        fd_first = 0;
        reset = 1'b0;
        load = 1'b0;
        enable = 1'b0;
        load2 = 1'b0;
        enable2 = 1'b0;
        dataMatrix = '0;

        repeat (3) @(negedge clk);
        check("reset_outs",
              {ser_data, ser_clk, ser_latch, frame_done, busy, row_idx},
              '0);
        reset = 1'b1;
        for (int r = 0; r < 8; r++) dataMatrix[r] = f0[r];
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("load_no_start", busy, 1'b0);
        enable = 1'b1;

        // Two full frames plus row 2 of a third; loads A then B.
        prev_sclk = 1'b0;
        for (int t = 1; t <= 1444; t++) begin
            @(negedge clk);
            fr = (t - 1) / 608;
            rw = ((t - 1) / 76) % 8;
            if (ser_clk && !prev_sclk) begin
                bits[fr][rw] = {bits[fr][rw][14:0], ser_data};
                nbits[fr][rw]++;
            end
            if (ser_latch) begin
                if (nlat[fr][rw] == 0) lat_at[fr][rw] = t;
                nlat[fr][rw]++;
            end
            if (frame_done) begin
                if (fd_n == 0) fd_first = t;
                fd_n++;
            end
            if (fr == 0 && (t - 1) % 76 == 64)
                check($sformatf("row_idx_r%0d", rw), row_idx, rw);
            prev_sclk = ser_clk;
            if (t == 238) begin
                for (int r = 0; r < 8; r++) dataMatrix[r] = 8'hFF;
                load = 1'b1;
            end
            if (t == 239) load = 1'b0;
            if (t == 608) begin
                for (int r = 0; r < 8; r++) dataMatrix[r] = fb[r];
                load = 1'b1;
            end
            if (t == 609) load = 1'b0;
            if (t == 1380) enable = 1'b0;
        end
        @(negedge clk);
        check("idle_after_drop",
              {ser_data, ser_clk, ser_latch, frame_done, busy, row_idx},
              '0);

        check("first_row_a5fe", bits[0][0], 16'hA5FE);
        check("first_row_latch", nlat[0][0], 2);
        for (int r = 0; r < 8; r++) begin
            check($sformatf("f0_bits_r%0d", r), bits[0][r],
                  row_word(f0[r], r));
            check($sformatf("f0_lat_r%0d", r), lat_at[0][r],
                  76 * r + 65);
            check($sformatf("f1_bits_r%0d", r), bits[1][r],
                  row_word(fb[r], r));
        end
        for (int r = 0; r < 3; r++) begin
            check($sformatf("f2_bits_r%0d", r), bits[2][r],
                  row_word(fb[r], r));
            check($sformatf("f2_lat_r%0d", r), nlat[2][r], 2);
        end
        check("frame_done_count", fd_n, 2);
        check("frame_done_cycle", fd_first, 608);

        act = 0;
        repeat (80) begin
            @(negedge clk);
            if (ser_clk || ser_latch || busy) act++;
        end
        check("idle_stays_idle", act, 0);

        // Reset in the middle of row 0 SHIFT.
        enable = 1'b1;
        act = 0;
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            if (ser_latch) act++;
        end
        reset = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("reset_mid_shift",
              {ser_data, ser_clk, ser_latch, frame_done, busy, row_idx},
              '0);
        repeat (80) begin
            @(negedge clk);
            if (ser_latch || busy) act++;
        end
        check("no_latch_after_reset", act, 0);

        enable = 1'b1;
        word = '0;
        act = 0;
        prev_sclk = 1'b0;
        for (int t = 1; t <= 76; t++) begin
            @(negedge clk);
            if (ser_clk && !prev_sclk) word = {word[14:0], ser_data};
            if (ser_latch) act++;
            prev_sclk = ser_clk;
            if (t == 1) check("restart_row", row_idx, 3'd0);
            if (t == 70) enable = 1'b0;
        end
        check("blank_after_reset", word, 16'h00FE);
        check("restart_latch", act, 2);

        // Minimum parameters: SCLK_DIV=1, HOLD_CYCLES=1.
        for (int r = 0; r < 8; r++) dataMatrix[r] = f0[r];
        load2 = 1'b1;
        @(negedge clk);
        load2 = 1'b0;
        enable2 = 1'b1;
        word = '0;
        tog = 0;
        act = 0;
        fd_first = 0;
        fd_n = 0;
        prev_sclk = 1'b0;
        for (int t = 1; t <= 68; t++) begin
            @(negedge clk);
            if (t <= 32 && ser_clk2 && !prev_sclk)
                word = {word[14:0], ser_data2};
            if (t >= 2 && t <= 32 && ser_clk2 != prev_sclk) tog++;
            if (t == 1) check("min_sclk_first", ser_clk2, 1'b0);
            if (ser_latch2) begin
                act++;
                if (fd_n == 0) fd_first = t;
                fd_n = t;
            end
            prev_sclk = ser_clk2;
        end
        enable2 = 1'b0;
        check("min_bits", word, 16'hA5FE);
        check("min_toggles", tog, 31);
        check("min_latch_cnt", act, 2);
        check("min_latch_first", fd_first, 33);
        check("min_row_period", fd_n - fd_first, 34);

        repeat (80) @(negedge clk);
        check("min_idle", {busy2, ser_clk2, ser_latch2, row_idx2}, '0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
